// File: rtl/muldiv_pkg.sv
// Shared types and op-code helpers for the iterative multiply/divide unit.
// Imported by the interface, the step datapath and the top level.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  localparam int OP_UNSIGNED_BIT = 0;

  // Multiply and divide codes all have the top bit clear.
  function automatic logic is_arith(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// The pipeline is the master; the unit is the slave.
interface muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on an {acc, shreg} register pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           fits;

  // Multiply consumes the multiplier LSB-first; the carry shifts into acc.
  assign sum     = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
  // Divide brings the next dividend bit in from the top of the quotient reg.
  assign shifted = {acc, shreg[WIDTH-1]};
  assign fits    = shifted >= {1'b0, operand};

  always_comb begin
    if (mode_div) begin
      // A successful trial leaves a remainder below the divisor, so it fits in WIDTH bits.
      acc_next   = fits ? (shifted[WIDTH-1:0] - operand) : shifted[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], fits};
    end else begin
      acc_next   = sum[WIDTH:1];
      shreg_next = {sum[0], shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with architectural HI/LO registers.
// Magnitudes are iterated one bit per clock; signs are reapplied on the FIN edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic               load_op, mthi_we, mtlo_we, step_en, fin_commit;
  logic [WIDTH-1:0]   acc_q, shreg_q, operand_q;
  logic [WIDTH-1:0]   acc_next, shreg_next;
  logic               mode_div_q, neg_lo_q, neg_hi_q, zero_q;
  logic               done_q, div_zero_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               op_signed, a_neg, b_neg, b_zero, last_step;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] product, product_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

  assign op_signed = ~bus.op[OP_UNSIGNED_BIT];
  assign a_neg     = op_signed & bus.a[WIDTH-1];
  assign b_neg     = op_signed & bus.b[WIDTH-1];
  assign abs_a     = a_neg ? -bus.a : bus.a;
  assign abs_b     = b_neg ? -bus.b : bus.b;
  assign b_zero    = bus.b == '0;
  assign last_step = cnt_q == CNT_W'(WIDTH - 1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && is_arith(bus.op))
          state_d = (is_div(bus.op) && b_zero) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        if (bus.cancel)     state_d = ST_IDLE;
        else if (last_step) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control strobes; cancel outranks both stepping and completion.
  always_comb begin
    load_op    = 1'b0;
    mthi_we    = 1'b0;
    mtlo_we    = 1'b0;
    step_en    = 1'b0;
    fin_commit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_op = bus.start && is_arith(bus.op);
        mthi_we = bus.start && (bus.op == OP_MTHI);
        mtlo_we = bus.start && (bus.op == OP_MTLO);
      end
      ST_RUN:  step_en    = !bus.cancel;
      ST_FIN:  fin_commit = !bus.cancel;
      default: ;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div   (mode_div_q),
    .acc        (acc_q),
    .shreg      (shreg_q),
    .operand    (operand_q),
    .acc_next   (acc_next),
    .shreg_next (shreg_next)
  );

  // Sign correction. The most-negative / -1 divide needs no special case:
  // both signs match, so the unsigned quotient 2^(WIDTH-1) passes through.
  assign product     = {acc_q, shreg_q};
  assign product_fix = neg_lo_q ? -product : product;
  assign quot_fix    = neg_lo_q ? -shreg_q : shreg_q;
  assign rem_fix     = neg_hi_q ? -acc_q : acc_q;
  assign res_hi      = mode_div_q ? rem_fix  : product_fix[2*WIDTH-1:WIDTH];
  assign res_lo      = mode_div_q ? quot_fix : product_fix[WIDTH-1:0];

  // Iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      shreg_q    <= '0;
      operand_q  <= '0;
      mode_div_q <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      zero_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (load_op) begin
      acc_q      <= '0;
      shreg_q    <= abs_a;
      operand_q  <= abs_b;
      mode_div_q <= is_div(bus.op);
      neg_lo_q   <= a_neg ^ b_neg;
      neg_hi_q   <= a_neg;
      zero_q     <= is_div(bus.op) && b_zero;
      cnt_q      <= '0;
    end else if (step_en) begin
      acc_q      <= acc_next;
      shreg_q    <= shreg_next;
      cnt_q      <= cnt_q + 1'b1;
    end
  end

  // Architectural HI/LO and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= fin_commit;
      div_zero_q <= fin_commit && zero_q;
      if (fin_commit && !zero_q) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (mthi_we) hi_q <= bus.a;
      if (mtlo_we) lo_q <= bus.a;
    end
  end

  assign bus.busy     = state_q != ST_IDLE;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: timing, arithmetic corner cases,
// HI/LO moves, start-while-busy, cancel and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge; returns in cycle 1 of the op.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_zero});
    end
    n_cmp++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult_signed();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    for (int c = 1; c <= 33; c++) begin
      n_cmp++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        n_bad++;
        $display("FAIL mult_busy cycle %0d: got busy,done=%b expected 10", c, {bus.busy, bus.done});
      end
      step();
    end
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b010) begin
      n_bad++;
      $display("FAIL mult_done_cycle34: got %b expected 010", {bus.busy, bus.done, bus.div_zero});
    end
    n_cmp++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_bad++;
      $display("FAIL mult_result: got %h expected ffffffffffffffeb", {bus.hi, bus.lo});
    end
    step();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL mult_done_width: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_back_to_back();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (33) step();
    n_cmp++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b1, 64'hFFFF_FFFE_0000_0001}) begin
      n_bad++;
      $display("FAIL multu_result: got done=%b %h expected done=1 fffffffe00000001", bus.done, {bus.hi, bus.lo});
    end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_accept: got busy,done=%b expected 10", {bus.busy, bus.done});
    end
    repeat (33) step();
    n_cmp++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFD}) begin
      n_bad++;
      $display("FAIL div_neg_result: got done=%b %h expected done=1 fffffffffffffffd", bus.done, {bus.hi, bus.lo});
    end
  endtask

  task automatic test_div_zero();
    issue(OP_MTHI, 32'd5, 32'd0);
    issue(OP_MTLO, 32'd6, 32'd0);
    issue(OP_DIVU, 32'd100, 32'd0);
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b100) begin
      n_bad++;
      $display("FAIL divz_cycle1: got %b expected 100", {bus.busy, bus.done, bus.div_zero});
    end
    step();
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b011) begin
      n_bad++;
      $display("FAIL divz_cycle2: got %b expected 011", {bus.busy, bus.done, bus.div_zero});
    end
    n_cmp++;
    if ({bus.hi, bus.lo} !== {32'd5, 32'd6}) begin
      n_bad++;
      $display("FAIL divz_hilo_kept: got %h expected 0000000500000006", {bus.hi, bus.lo});
    end
    step();
    n_cmp++;
    if ({bus.done, bus.div_zero} !== 2'b00) begin
      n_bad++;
      $display("FAIL divz_pulse_width: got %b expected 00", {bus.done, bus.div_zero});
    end
  endtask

  task automatic test_div_overflow();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (33) step();
    n_cmp++;
    if ({bus.done, bus.div_zero, bus.hi, bus.lo} !== {2'b10, 32'h0, 32'h8000_0000}) begin
      n_bad++;
      $display("FAIL div_overflow: got done,dz=%b %h expected 10 0000000080000000",
               {bus.done, bus.div_zero}, {bus.hi, bus.lo});
    end
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (33) step();
    n_cmp++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL divu_100_7: got done=%b %h expected done=1 000000020000000e", bus.done, {bus.hi, bus.lo});
    end
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    n_cmp++;
    if ({bus.busy, bus.done, bus.hi} !== {2'b00, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL mthi: got busy,done=%b hi=%h expected 00 12345678", {bus.busy, bus.done}, bus.hi);
    end
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    n_cmp++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 32'h1234_5678, 32'h9ABC_DEF0}) begin
      n_bad++;
      $display("FAIL mtlo: got busy,done=%b %h expected 00 123456789abcdef0",
               {bus.busy, bus.done}, {bus.hi, bus.lo});
    end
    // Reserved code must neither start nor move anything.
    issue(3'b110, 32'hDEAD_BEEF, 32'd1);
    n_cmp++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'h1234_5678, 32'h9ABC_DEF0}) begin
      n_bad++;
      $display("FAIL reserved_op: got busy=%b %h expected 0 123456789abcdef0", bus.busy, {bus.hi, bus.lo});
    end
  endtask

  task automatic test_start_while_busy();
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (4) step();
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    repeat (3) step();
    bus.start = 1'b0;
    repeat (26) step();
    n_cmp++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'd0, 32'd42}) begin
      n_bad++;
      $display("FAIL busy_start_ignored: got done=%b %h expected done=1 000000000000002a", bus.done, {bus.hi, bus.lo});
    end
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL no_queue: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_cancel();
    logic done_seen;
    issue(OP_MULT, 32'd3, 32'd5);
    repeat (9) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 32'd0, 32'd42}) begin
      n_bad++;
      $display("FAIL cancel_run: got busy,done=%b %h expected 00 000000000000002a",
               {bus.busy, bus.done}, {bus.hi, bus.lo});
    end
    done_seen = 1'b0;
    repeat (30) begin
      done_seen = done_seen | bus.done | bus.busy;
      step();
    end
    n_cmp++;
    if (done_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_quiet: got activity=%b expected 0", done_seen);
    end
    // Cancel while in FIN suppresses completion.
    issue(OP_DIVU, 32'd9, 32'd0);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      n_bad++;
      $display("FAIL cancel_fin: got %b expected 000", {bus.busy, bus.done, bus.div_zero});
    end
    // Cancel in IDLE does not block a simultaneous start.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = OP_DIVU;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    step();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cancel_idle_start: got busy=%b expected 1", bus.busy);
    end
    repeat (33) step();
    n_cmp++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL cancel_idle_result: got done=%b %h expected done=1 000000020000000e", bus.done, {bus.hi, bus.lo});
    end
  endtask

  task automatic test_async_reset();
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (19) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo} !== 67'h0) begin
      n_bad++;
      $display("FAIL async_reset: got busy,done,dz=%b %h expected 000 0",
               {bus.busy, bus.done, bus.div_zero}, {bus.hi, bus.lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++;
      $display("FAIL after_reset_idle: got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 3'b000;
    bus.a      = '0;
    bus.b      = '0;

    test_reset();
    test_mult_signed();
    test_back_to_back();
    test_div_zero();
    test_div_overflow();
    test_mthi_mtlo();
    test_start_while_busy();
    test_cancel();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
